sram_rmw_ctrl: RTL and testbench

SRAM_RMW_CTRL -- requirements
Module: sram_rmw_ctrl

---
 rtl/sram_rmw_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sram_rmw_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rmw_ctrl.sv
// sram_rmw_ctrl
// Read-add-write controller for an asynchronous 16-bit SRAM that is shared
// with an Arduino Due. One accepted start reads a word, adds an operand,
// writes the 16-bit sum back and reports result/carry. The FPGA may use the
// bus only while fpga_enable is high. If the grant is withdrawn while an
// operation is on the bus, the operation is abandoned.
//
// Optional feature: define SRAM_VERIFY_EN to re-read the written word and
// flag a mismatch on err. In the default build err is tied to 0.
//
// Timing from the edge that samples start (cycles counted after that edge):
//   READ RD_WAIT, SUM 1, WRITE WR_WAIT, HOLD 1, [VERIFY RD_WAIT], DONE 1
// At the defaults done is therefore high in the 7th cycle, or the 9th with
// verify.
module sram_rmw_ctrl #(
  parameter int RD_WAIT = 2,  // cycles oe is low per read, 1..15
  parameter int WR_WAIT = 2   // cycles we is low per write, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fpga_enable,
  input  logic        start,
  input  logic [21:0] addr_in,
  input  logic [15:0] operand,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        carry,
  output logic        err,
  output logic [15:0] result,
  output logic [21:0] addr,
  inout  wire  [15:0] data,
  output logic        ce,
  output logic        oe,
  output logic        we,
  output logic        lb,
  output logic        ce2
);

  // Wait counters are loaded with (cycles - 1) and count down to zero.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SUM,
    WRITE,
    HOLD,
`ifdef SRAM_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;

  // Operation registers.
  logic [21:0] addr_q;
  logic [15:0] op_q;
  logic [15:0] rdata_q;
  logic [16:0] sum_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic        abort_q;

  // Single-cycle strobes from the FSM to the datapath.
  logic        accept;
  logic        capture;
  logic        sum_en;
  logic        commit;
  logic        abort_d;

  // Bus phase decode.
  logic        bus_on;
  logic        rd_phase;
  logic        wr_phase;
  logic        drive;

  // State and wait-counter registers; an asserted reset forces IDLE at once,
  // which releases every SRAM strobe (including we) without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic, wait counting and datapath strobes; a lost bus grant
  // overrides whatever the current state would have done.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    accept  = 1'b0;
    capture = 1'b0;
    sum_en  = 1'b0;
    commit  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && fpga_enable) begin
          accept  = 1'b1;
          state_d = READ;
          wait_d  = RD_LOAD;
        end
      end

      READ: begin
        if (wait_q == 4'd0) begin
          capture = 1'b1;
          state_d = SUM;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      SUM: begin
        sum_en  = 1'b1;
        state_d = WRITE;
        wait_d  = WR_LOAD;
      end

      WRITE: begin
        if (wait_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      HOLD: begin
`ifdef SRAM_VERIFY_EN
        state_d = VERIFY;
        wait_d  = RD_LOAD;
`else
        state_d = DONE;
        commit  = 1'b1;
`endif
      end

`ifdef SRAM_VERIFY_EN
      VERIFY: begin
        if (wait_q == 4'd0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Grant withdrawn mid-operation: drop everything and go back to IDLE.
    // DONE already has the bus released, so it is allowed to finish.
    if (!fpga_enable && (state_q != IDLE) && (state_q != DONE)) begin
      state_d = IDLE;
      wait_d  = 4'd0;
      capture = 1'b0;
      sum_en  = 1'b0;
      commit  = 1'b0;
      abort_d = 1'b1;
    end
  end

  // Datapath: latch the request, capture read data, form the 17-bit sum,
  // and publish result/carry only on entry to DONE so an abort leaves the
  // previous result untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 22'd0;
      op_q     <= 16'd0;
      rdata_q  <= 16'd0;
      sum_q    <= 17'd0;
      result_q <= 16'd0;
      carry_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= abort_d;
      if (accept) begin
        addr_q <= addr_in;
        op_q   <= operand;
      end
      if (capture) begin
        rdata_q <= data;
      end
      if (sum_en) begin
        sum_q <= {1'b0, rdata_q} + {1'b0, op_q};
      end
      if (commit) begin
        result_q <= sum_q[15:0];
        carry_q  <= sum_q[16];
      end
    end
  end

`ifdef SRAM_VERIFY_EN
  logic err_q;

  // Verify flag: compare the re-read word against the written sum on the
  // last VERIFY cycle, which is also the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= (data != sum_q[15:0]);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // SRAM strobe decode straight from the state register, so reset releases
  // the bus asynchronously. oe and we are low in disjoint states, and data is
  // driven only in WRITE/HOLD where oe is high.
  always_comb begin
    bus_on   = 1'b0;
    rd_phase = 1'b0;
    wr_phase = 1'b0;
    drive    = 1'b0;
    case (state_q)
      READ:    begin bus_on = 1'b1; rd_phase = 1'b1; end
      SUM:     begin bus_on = 1'b1; end
      WRITE:   begin bus_on = 1'b1; wr_phase = 1'b1; drive = 1'b1; end
      HOLD:    begin bus_on = 1'b1; drive = 1'b1; end
`ifdef SRAM_VERIFY_EN
      VERIFY:  begin bus_on = 1'b1; rd_phase = 1'b1; end
`endif
      default: begin bus_on = 1'b0; end
    endcase
  end

  assign ce     = ~bus_on;
  assign ce2    = bus_on;
  assign lb     = ~bus_on;
  assign oe     = ~rd_phase;
  assign we     = ~wr_phase;
  assign data   = drive ? sum_q[15:0] : 16'bz;

  assign addr   = addr_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign abort  = abort_q;
  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// tb_sram_rmw_ctrl
// Self-checking bench for sram_rmw_ctrl at default RD_WAIT/WR_WAIT. It holds
// a 16-word SRAM model (indexed by addr[3:0]) and a reference model that
// describes each operation as a timeline of bus phases counted in cycles
// after the accepting edge. Outputs are compared to the reference on every
// falling edge; directed tests add literal expectations. Define
// SRAM_VERIFY_EN for both files to cover the verify build.
module tb_sram_rmw_ctrl;

  localparam int RD = 2;
  localparam int WR = 2;
`ifdef SRAM_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  // Timeline boundaries of one operation (cycle 1 = first cycle after start).
  localparam int P1 = RD;              // last read cycle
  localparam int P2 = RD + 1;          // add cycle
  localparam int P3 = P2 + WR;         // last write-strobe cycle
  localparam int P4 = P3 + 1;          // data-hold cycle
  localparam int P5 = P4 + VER * RD;   // last verify-read cycle
  localparam int L  = P5 + 1;          // done cycle

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fpga_enable = 1'b1;
  logic        start = 1'b0;
  logic [21:0] addr_in = 22'd0;
  logic [15:0] operand = 16'd0;
  logic        busy, done, abort, carry, err;
  logic [15:0] result;
  logic [21:0] addr;
  wire  [15:0] data;
  logic        ce, oe, we, lb, ce2;

  int n_vec  = 0;
  int n_fail = 0;

  sram_rmw_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fpga_enable (fpga_enable),
    .start       (start),
    .addr_in     (addr_in),
    .operand     (operand),
    .busy        (busy),
    .done        (done),
    .abort       (abort),
    .carry       (carry),
    .err         (err),
    .result      (result),
    .addr        (addr),
    .data        (data),
    .ce          (ce),
    .oe          (oe),
    .we          (we),
    .lb          (lb),
    .ce2         (ce2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [15:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_a  = 4'd0;
  logic [15:0] pl_v  = 16'd0;
  logic        corrupt_wr = 1'b0;

  // Preload port for the bench, otherwise store whatever is on the bus while
  // the write strobe is low (or a fixed bad word when corruption is on).
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_v;
    else if (!ce && ce2 && !we) mem[addr[3:0]] <= corrupt_wr ? 16'h1234 : data;
  end

  // ---------------- reference model ----------------
  logic        m_active;
  int          m_k;
  logic        m_abort;
  logic [21:0] m_addr;
  logic [16:0] m_sum;
  logic [15:0] m_result;
  logic        m_carry;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_abort  <= 1'b0;
      m_addr   <= 22'd0;
      m_sum    <= 17'd0;
      m_result <= 16'd0;
      m_carry  <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      m_abort <= 1'b0;
      if (!m_active) begin
        if (start && fpga_enable) begin
          m_active <= 1'b1;
          m_k      <= 1;
          m_addr   <= addr_in;
          m_sum    <= 17'(mem[addr_in[3:0]]) + 17'(operand);
        end
      end else if (m_k < L && !fpga_enable) begin
        m_active <= 1'b0;
        m_k      <= 0;
        m_abort  <= 1'b1;
      end else if (m_k == L) begin
        m_active <= 1'b0;
        m_k      <= 0;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == L) begin
          m_result <= m_sum[15:0];
          m_carry  <= m_sum[16];
          m_err    <= (VER != 0) && (mem[m_addr[3:0]] != m_sum[15:0]);
        end
      end
    end
  end

  logic        in_rd, in_wr, in_drv, on_bus, m_done;
  logic [15:0] exp_data;
  logic [9:0]  exp_ctrl, act_ctrl;

  assign in_rd    = m_active && (m_k <= P1 || (m_k > P4 && m_k <= P5));
  assign in_wr    = m_active && m_k > P2 && m_k <= P3;
  assign in_drv   = m_active && m_k > P2 && m_k <= P4;
  assign on_bus   = m_active && m_k < L;
  assign m_done   = m_active && m_k == L;
  assign exp_data = in_rd ? mem[m_addr[3:0]] : (in_drv ? m_sum[15:0] : 16'h0000);
  assign exp_ctrl = {!on_bus, on_bus, !on_bus, !in_rd, !in_wr, m_active,
                     m_done, m_abort, m_carry, m_err};
  assign act_ctrl = {ce, ce2, lb, oe, we, busy, done, abort, carry, err};

  // SRAM read drive, plus a zero keeper whenever the controller should not
  // be driving: any unexpected controller drive then shows up on data.
  assign data = (!ce && ce2 && !oe) ? mem[addr[3:0]]
              : ((oe && !in_drv) ? 16'h0000 : 16'bz);

  // Per-cycle comparison against the reference model plus bus invariants.
  always @(negedge clk) begin
    check("ctrl{ce,ce2,lb,oe,we,busy,done,abort,carry,err}", act_ctrl, exp_ctrl);
    check("result", result, m_result);
    check("addr", addr, m_addr);
    check("data", data, exp_data);
    check("oe_and_we_both_low", (!oe && !we), 1'b0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input logic [3:0] a, input logic [15:0] v);
    pl_a  = a;
    pl_v  = v;
    pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one start and return the cycle (1-based, after the sampling edge)
  // in which done is first seen; returns 40 on timeout. Ends back in IDLE.
  task automatic run_op(input logic [21:0] a, input logic [15:0] op,
                        output int lat);
    lat     = 0;
    addr_in = a;
    operand = op;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    #1;
    @(posedge clk); #1;
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam int EXP_LAT = (VER != 0) ? 9 : 7;

  initial begin
    int lat;
    int nd;

    // Reset with memory cleared.
    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_ce", ce, 1'b1);
    check("reset_result", result, 16'h0000);
    check("reset_addr", addr, 22'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word[3]=0x0010 + 5.
    preload(4'd3, 16'h0010);
    run_op(22'd3, 16'h0005, lat);
    check("lat_basic", lat, EXP_LAT);
    check("res_basic", result, 16'h0015);
    check("carry_basic", carry, 1'b0);
    check("mem3_basic", mem[3], 16'h0015);

    // word[0]=0xFFFF + 1 wraps with carry.
    preload(4'd0, 16'hFFFF);
    run_op(22'd0, 16'h0001, lat);
    check("lat_wrap", lat, EXP_LAT);
    check("res_wrap", result, 16'h0000);
    check("carry_wrap", carry, 1'b1);
    check("mem0_wrap", mem[0], 16'h0000);

    // A few more patterns, including high address bits.
    preload(4'd5, 16'h1234);
    run_op(22'd5, 16'h8000, lat);
    check("res_p1", result, 16'h9234);
    check("carry_p1", carry, 1'b0);
    preload(4'd15, 16'h8001);
    run_op(22'd15, 16'h7FFF, lat);
    check("res_p2", result, 16'h0000);
    check("carry_p2", carry, 1'b1);
    preload(4'd7, 16'hABCD);
    run_op(22'h3FFFC7, 16'h1111, lat);
    check("res_p3", result, 16'hBCDE);
    check("addr_p3", addr, 22'h3FFFC7);
    check("mem7_p3", mem[7], 16'hBCDE);

    // Start while busy is ignored: exactly one done, first request's result.
    preload(4'd2, 16'h0002);
    preload(4'd4, 16'h0040);
    addr_in = 22'd2;
    operand = 16'h0003;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    addr_in = 22'd4;
    operand = 16'h0009;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count_dones(20, nd);
    check("dones_busy_start", nd, 1);
    check("res_busy_start", result, 16'h0005);
    check("mem4_untouched", mem[4], 16'h0040);

    // Start with the grant low is ignored.
    fpga_enable = 1'b0;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    fpga_enable = 1'b1;
    check("busy_no_grant", busy, 1'b0);
    count_dones(12, nd);
    check("dones_no_grant", nd, 0);
    check("mem4_no_grant", mem[4], 16'h0040);

    // Grant dropped during WRITE: abort pulse, bus released, no done.
    preload(4'd9, 16'h0100);
    addr_in = 22'd9;
    operand = 16'h0001;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("we_low_in_write", we, 1'b0);
    fpga_enable = 1'b0;
    @(posedge clk); #1;
    check("abort_pulse", abort, 1'b1);
    check("abort_ce", ce, 1'b1);
    check("abort_we", we, 1'b1);
    check("abort_busy", busy, 1'b0);
    fpga_enable = 1'b1;
    @(posedge clk); #1;
    check("abort_one_cycle", abort, 1'b0);
    count_dones(12, nd);
    check("dones_after_abort", nd, 0);
    check("res_after_abort", result, 16'h0005);

`ifdef SRAM_VERIFY_EN
    // Corrupted write is caught; a clean write is not flagged.
    preload(4'd6, 16'h0100);
    corrupt_wr = 1'b1;
    run_op(22'd6, 16'h0001, lat);
    corrupt_wr = 1'b0;
    check("lat_verify", lat, 9);
    check("err_corrupt", err, 1'b1);
    check("res_corrupt", result, 16'h0101);
    run_op(22'd6, 16'h0001, lat);
    check("err_clean", err, 1'b0);
    check("res_clean", result, 16'h1235);
`endif

    // Reset pulsed mid-READ releases the bus immediately.
    preload(4'd1, 16'h0007);
    addr_in = 22'd1;
    operand = 16'h0001;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("oe_low_in_read", oe, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ce", ce, 1'b1);
    check("rst_ce2", ce2, 1'b0);
    check("rst_oe", oe, 1'b1);
    check("rst_we", we, 1'b1);
    check("rst_lb", lb, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addr, 22'd0);
    check("rst_result", result, 16'h0000);
    check("rst_carry", carry, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(22'd1, 16'h0001, lat);
    check("res_after_reset", result, 16'h0008);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
